mc6809_bus_master: RTL and testbench
====================================

Name: mc6809_bus_master

Overview:
- Bus initiator that runs single 6809-style E/Q bus cycles (address, R/W, data) on the local SRAM bus, on request from an internal agent.
- Typical agents are a boot loader or a test engine that must read or write SRAM without the CPU.
- Its outputs drive the same E/RW/address/data nets that the SRAM chip-select decoder and strobe generator consume.
- It generates one E cycle per request, then parks the bus in a safe idle state.

Parameters:
- QUARTER_CLKS, 2, system clocks per E/Q quarter-phase. Minimum 1; values below 1 are illegal.
- ADDR_W, 16, address width.
- DATA_W, 8, data width.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req  in  1  request strobe. Sampled in IDLE only.
- i_wr  in  1  1 = write cycle, 0 = read cycle. Captured with i_req.
- i_addr  in  ADDR_W  request address. Captured with i_req.
- i_wdata  in  DATA_W  write data. Captured with i_req.
- o_ack  out  1  one-clock pulse when the cycle completes.
- o_rdata  out  DATA_W  read data. Valid from o_ack onward; holds until the next read completes.
- o_busy  out  1  high from the clock after acceptance through the HOLD clock.
- o_E  out  1  6809 E clock to the bus.
- o_Q  out  1  6809 Q clock, leading E by one quarter.
- o_RW  out  1  bus R/W; low means write.
- o_addr  out  ADDR_W  bus address.
- o_data_out  out  DATA_W  bus write data.
- o_data_oe  out  1  bus data driver enable.
- i_data_in  in  DATA_W  bus read data.

Behaviour:
- All outputs are registered.
- Reset values: o_E=0, o_Q=0, o_RW=1, o_addr=0, o_data_out=0, o_data_oe=0, o_ack=0, o_rdata=0, o_busy=0, state=IDLE, quarter counter=0.
- States: IDLE, P0, P1, P2, P3, HOLD.
  - P0: E=0, Q=0. Address and RW valid.
  - P1: E=0, Q=1.
  - P2: E=1, Q=1.
  - P3: E=1, Q=0.
- Transitions:
  - IDLE -> P0 when i_req=1. Latch addr, wr and wdata on the same edge.
  - P0 -> P1 -> P2 -> P3 after QUARTER_CLKS clocks in each state.
  - P3 -> HOLD after QUARTER_CLKS clocks.
  - HOLD -> IDLE after 1 clock.
- Quarter counter:
  - Counts 0 to QUARTER_CLKS-1.
  - Clears on every state change.
  - Is sized by $clog2(QUARTER_CLKS)+1 so that QUARTER_CLKS=1 is legal.
- RW, address and data:
  - o_addr updates on acceptance and holds through HOLD and IDLE. It is never cleared except by reset.
  - o_RW = ~wr from P0 through HOLD. It returns to 1 on entry to IDLE.
  - Write cycles: o_data_out is loaded at acceptance. o_data_oe=1 in P1, P2, P3 and HOLD, giving one clock of data hold after E falls. o_data_oe=0 in all other states.
- Read capture: o_rdata <= i_data_in on the final clock of P3, which is the edge where E falls. Write cycles never change o_rdata.
- o_ack:
  - Pulses for exactly one clock, during HOLD.
  - The requester must drop or replace i_req in the ack clock. i_req=1 in the IDLE clock after ack is a new request.
- Latency: accept edge to o_ack = 4*QUARTER_CLKS + 1 clocks. Minimum request spacing is 4*QUARTER_CLKS + 2 clocks.
- i_req while busy is ignored and not queued. Changes to i_wr, i_addr or i_wdata while busy have no effect.
- Reset mid-cycle:
  - All outputs return to reset values immediately (asynchronously). In particular, E drops so that no write strobe persists.
  - No o_ack is issued.
  - The aborted cycle is lost. The agent must reissue it after reset.

Decomposition:
- Shared package mc6809_bus_pkg:
  - State enum (IDLE, P0, P1, P2, P3, HOLD).
  - Per-state E/Q encoding constants.
  - Default ADDR_W/DATA_W.
- One sub-module: mc6809_quarter_timer, the parameterised quarter counter with a terminal-count output. The FSM and output registers stay in the top-level module.

Test Plan:
- Read, QUARTER_CLKS=2, i_addr=16'hC000, bus returns 8'h5A:
  - E high in clocks 5-8 after accept; Q high in clocks 3-6.
  - o_ack in clock 9; o_rdata=8'h5A; o_RW=1 throughout; o_data_oe never 1.
- Write, addr 16'h0123, wdata 8'hA7:
  - o_RW=0 from P0 through HOLD; o_data_out=8'hA7.
  - o_data_oe=1 from P1 through HOLD; o_RW=1 on return to IDLE.
- Back-to-back: write 16'h0010/8'h11, then read 16'h0010 with i_req held through the ack clock:
  - Second cycle is accepted exactly in the IDLE clock after ack.
  - No cycle is dropped or duplicated.
- i_req pulsed while busy, and i_addr changed mid-cycle:
  - No extra cycle; o_addr unchanged; a single o_ack.
- QUARTER_CLKS=1 read:
  - Each state lasts 1 clock; o_ack 5 clocks after accept.
  - o_rdata equals i_data_in as sampled in the P3 clock.
- i_reset asserted during P2 of a write:
  - o_E=0, o_RW=1, o_data_oe=0 with no clock edge.
  - No o_ack; IDLE after release; the next request completes normally.

Source files
------------

// File: rtl/mc6809_bus_pkg.sv
// Shared definitions for the 6809-style bus master: phase states, E/Q
// encodings per phase, and default bus widths.
package mc6809_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;

  // One E cycle is four quarter phases, bracketed by IDLE and a one-clock HOLD.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_HOLD = 3'd5
  } state_t;

  // {E, Q} per phase; Q leads E by one quarter.
  localparam logic [1:0] EQ_IDLE = 2'b00;
  localparam logic [1:0] EQ_P0   = 2'b00;
  localparam logic [1:0] EQ_P1   = 2'b01;
  localparam logic [1:0] EQ_P2   = 2'b11;
  localparam logic [1:0] EQ_P3   = 2'b10;

  function automatic logic [1:0] eq_of(input state_t s);
    case (s)
      ST_P0:   eq_of = EQ_P0;
      ST_P1:   eq_of = EQ_P1;
      ST_P2:   eq_of = EQ_P2;
      ST_P3:   eq_of = EQ_P3;
      default: eq_of = EQ_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mc6809_quarter_timer.sv
// Quarter-phase counter: counts 0..QUARTER_CLKS-1 and saturates there.
// Ports: i_clk, i_reset (async, active high), i_clear (restart at 0),
//        o_terminal_c (combinational, count has reached QUARTER_CLKS-1).
module mc6809_quarter_timer #(
  parameter int unsigned QUARTER_CLKS = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_terminal_c
);

  // One extra bit keeps the width non-zero when QUARTER_CLKS is 1.
  localparam int unsigned CW = $clog2(QUARTER_CLKS) + 1;
  localparam logic [CW-1:0] LAST = CW'(QUARTER_CLKS - 1);

  logic [CW-1:0] count_q;

  assign o_terminal_c = (count_q == LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)           count_q <= '0;
    else if (i_clear)      count_q <= '0;
    else if (!o_terminal_c) count_q <= count_q + CW'(1);
  end

endmodule

// File: rtl/mc6809_bus_master.sv
// Runs one 6809-style E/Q bus cycle per request from an internal agent,
// then parks the bus idle (E=0, RW=1, data driver off).
// Ports: i_clk, i_reset (async, active high); request side i_req, i_wr,
//        i_addr, i_wdata -> o_ack, o_rdata, o_busy; bus side o_E, o_Q, o_RW,
//        o_addr, o_data_out, o_data_oe, i_data_in. All outputs registered.
module mc6809_bus_master
  import mc6809_bus_pkg::*;
#(
  parameter int unsigned QUARTER_CLKS = 2,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic              o_E,
  output logic              o_Q,
  output logic              o_RW,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_data_oe,
  input  logic [DATA_W-1:0] i_data_in
);

  state_t     state_q, state_d;
  logic       wr_q, wr_d;
  logic       terminal_c;
  logic       accept_c;
  logic       capture_c;
  logic [1:0] eq_d;
  logic       rw_d, oe_d, ack_d, busy_d;

  mc6809_quarter_timer #(.QUARTER_CLKS(QUARTER_CLKS)) u_timer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (state_d != state_q),
    .o_terminal_c (terminal_c)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    case (state_q)
      ST_IDLE: if (i_req) begin
        state_d  = ST_P0;
        accept_c = 1'b1;
      end
      ST_P0:   if (terminal_c) state_d = ST_P1;
      ST_P1:   if (terminal_c) state_d = ST_P2;
      ST_P2:   if (terminal_c) state_d = ST_P3;
      ST_P3:   if (terminal_c) begin
        state_d   = ST_HOLD;
        capture_c = !wr_q;          // edge where E falls
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    wr_d   = accept_c ? i_wr : wr_q;
    eq_d   = eq_of(state_d);
    rw_d   = (state_d == ST_IDLE) ? 1'b1 : !wr_d;
    // Driver stays on through HOLD for one clock of hold after E falls.
    oe_d   = wr_d && (state_d inside {ST_P1, ST_P2, ST_P3, ST_HOLD});
    ack_d  = (state_d == ST_HOLD);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      wr_q       <= 1'b0;
      o_E        <= 1'b0;
      o_Q        <= 1'b0;
      o_RW       <= 1'b1;
      o_addr     <= '0;
      o_data_out <= '0;
      o_data_oe  <= 1'b0;
      o_ack      <= 1'b0;
      o_rdata    <= '0;
      o_busy     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      {o_E, o_Q} <= eq_d;
      o_RW       <= rw_d;
      o_data_oe  <= oe_d;
      o_ack      <= ack_d;
      o_busy     <= busy_d;
      if (accept_c)         o_addr     <= i_addr;
      if (accept_c && i_wr) o_data_out <= i_wdata;
      if (capture_c)        o_rdata    <= i_data_in;
    end
  end

endmodule

// File: tb/tb_mc6809_bus_master.sv
// Directed bench for mc6809_bus_master: instance a (QUARTER_CLKS=2) on a small
// SRAM model, instance b (QUARTER_CLKS=1) with a per-clock changing data bus.
module tb_mc6809_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a signals
  logic        a_rst, a_req, a_wr;
  logic [15:0] a_iaddr;
  logic [7:0]  a_wdata, a_din;
  logic        a_ack, a_busy, a_E, a_Q, a_RW, a_oe;
  logic [7:0]  a_rdata, a_dout;
  logic [15:0] a_addr;

  // Instance b signals
  logic        b_rst, b_req, b_wr;
  logic [15:0] b_iaddr;
  logic [7:0]  b_wdata, b_din;
  logic        b_ack, b_busy, b_E, b_Q, b_RW, b_oe;
  logic [7:0]  b_rdata, b_dout;
  logic [15:0] b_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:65535];

  mc6809_bus_master #(.QUARTER_CLKS(2), .ADDR_W(16), .DATA_W(8)) dut_a (
    .i_clk(clk), .i_reset(a_rst), .i_req(a_req), .i_wr(a_wr),
    .i_addr(a_iaddr), .i_wdata(a_wdata), .o_ack(a_ack), .o_rdata(a_rdata),
    .o_busy(a_busy), .o_E(a_E), .o_Q(a_Q), .o_RW(a_RW), .o_addr(a_addr),
    .o_data_out(a_dout), .o_data_oe(a_oe), .i_data_in(a_din)
  );

  mc6809_bus_master #(.QUARTER_CLKS(1), .ADDR_W(16), .DATA_W(8)) dut_b (
    .i_clk(clk), .i_reset(b_rst), .i_req(b_req), .i_wr(b_wr),
    .i_addr(b_iaddr), .i_wdata(b_wdata), .o_ack(b_ack), .o_rdata(b_rdata),
    .o_busy(b_busy), .o_E(b_E), .o_Q(b_Q), .o_RW(b_RW), .o_addr(b_addr),
    .o_data_out(b_dout), .o_data_oe(b_oe), .i_data_in(b_din)
  );

  // SRAM model: reads follow the address, writes land when E falls.
  assign a_din = mem[a_addr];
  always @(negedge a_E) if (!a_RW && !a_rst) mem[a_addr] = a_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Records instance-a outputs in clocks 1..ncyc after the accept edge.
  task automatic trace_a(input int ncyc, input int drop_at,
                         output logic [31:0] e, output logic [31:0] q,
                         output logic [31:0] ack, output logic [31:0] rw,
                         output logic [31:0] oe, output logic [31:0] busy);
    e = '0; q = '0; ack = '0; rw = '0; oe = '0; busy = '0;
    for (int k = 1; k <= ncyc; k++) begin
      e[k] = a_E; q[k] = a_Q; ack[k] = a_ack;
      rw[k] = a_RW; oe[k] = a_oe; busy[k] = a_busy;
      if (k == drop_at) a_req = 1'b0;
      step();
    end
  endtask

  logic [31:0] te, tq, tack, trw, toe, tbusy;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hC000] = 8'h5A;
    mem[16'h0200] = 8'h3C;
    a_rst = 1'b1; a_req = 1'b0; a_wr = 1'b0; a_iaddr = '0; a_wdata = '0;
    b_rst = 1'b1; b_req = 1'b0; b_wr = 1'b0; b_iaddr = '0; b_wdata = '0; b_din = '0;

    // Reset values, before any clock edge
    #2;
    chk("reset_ctl_a", 32'({a_E, a_Q, a_RW, a_oe, a_ack, a_busy}), 32'b001000);
    chk("reset_data_a", {a_addr, a_dout, a_rdata}, 32'h0);
    chk("reset_ctl_b", 32'({b_E, b_Q, b_RW, b_oe, b_ack, b_busy}), 32'b001000);
    step(); step();
    a_rst = 1'b0; b_rst = 1'b0;
    step();

    // Read, QUARTER_CLKS=2
    a_req = 1'b1; a_wr = 1'b0; a_iaddr = 16'hC000;
    step();
    a_req = 1'b0;
    trace_a(12, 0, te, tq, tack, trw, toe, tbusy);
    chk("rd_E", te, 32'h0000_01E0);
    chk("rd_Q", tq, 32'h0000_0078);
    chk("rd_ack", tack, 32'h0000_0200);
    chk("rd_RW", trw, 32'h0000_1FFE);
    chk("rd_oe", toe, 32'h0);
    chk("rd_busy", tbusy, 32'h0000_03FE);
    chk("rd_rdata", 32'(a_rdata), 32'h5A);
    chk("rd_addr", 32'(a_addr), 32'hC000);

    // Write 0123 <- A7
    a_req = 1'b1; a_wr = 1'b1; a_iaddr = 16'h0123; a_wdata = 8'hA7;
    step();
    a_req = 1'b0;
    trace_a(12, 0, te, tq, tack, trw, toe, tbusy);
    chk("wr_E", te, 32'h0000_01E0);
    chk("wr_ack", tack, 32'h0000_0200);
    chk("wr_RW", trw, 32'h0000_1C00);
    chk("wr_oe", toe, 32'h0000_03F8);
    chk("wr_dout", 32'(a_dout), 32'hA7);
    chk("wr_mem", 32'(mem[16'h0123]), 32'hA7);
    chk("wr_rdata_kept", 32'(a_rdata), 32'h5A);

    // Back-to-back: write 0010 <- 11, then read 0010 with i_req held through ack
    a_req = 1'b1; a_wr = 1'b1; a_iaddr = 16'h0010; a_wdata = 8'h11;
    step();
    a_wr = 1'b0;
    trace_a(24, 11, te, tq, tack, trw, toe, tbusy);
    chk("b2b_ack", tack, 32'h0008_0200);
    chk("b2b_busy", tbusy, 32'h000F_FBFE);
    chk("b2b_RW", trw, 32'h01FF_FC00);
    chk("b2b_rdata", 32'(a_rdata), 32'h11);

    // i_req pulsed and address/wr changed while busy
    a_req = 1'b1; a_wr = 1'b0; a_iaddr = 16'h0200;
    step();
    a_req = 1'b0;
    tack = '0; trw = '0; tbusy = '0;
    for (int k = 1; k <= 14; k++) begin
      tack[k] = a_ack; trw[k] = a_RW; tbusy[k] = a_busy;
      if (k == 3) begin
        a_req = 1'b1; a_iaddr = 16'h0300; a_wr = 1'b1; a_wdata = 8'h55;
      end
      if (k == 4) a_req = 1'b0;
      step();
    end
    chk("busy_ack", tack, 32'h0000_0200);
    chk("busy_busy", tbusy, 32'h0000_03FE);
    chk("busy_RW", trw, 32'h0000_7FFE);
    chk("busy_addr", 32'(a_addr), 32'h0200);
    chk("busy_rdata", 32'(a_rdata), 32'h3C);
    a_wr = 1'b0;

    // QUARTER_CLKS=1 read, data bus changes every clock
    b_req = 1'b1; b_wr = 1'b0; b_iaddr = 16'h0777;
    step();
    b_req = 1'b0;
    te = '0; tq = '0; tack = '0; tbusy = '0;
    for (int k = 1; k <= 8; k++) begin
      b_din = 8'h10 + 8'(k);
      te[k] = b_E; tq[k] = b_Q; tack[k] = b_ack; tbusy[k] = b_busy;
      step();
    end
    chk("q1_E", te, 32'h0000_0018);
    chk("q1_Q", tq, 32'h0000_000C);
    chk("q1_ack", tack, 32'h0000_0020);
    chk("q1_busy", tbusy, 32'h0000_003E);
    chk("q1_rdata", 32'(b_rdata), 32'h14);
    chk("q1_addr", 32'(b_addr), 32'h0777);

    // Reset during P2 of a write
    a_req = 1'b1; a_wr = 1'b1; a_iaddr = 16'h0400; a_wdata = 8'h99;
    step();
    a_req = 1'b0;
    step(); step(); step(); step();
    chk("rst_pre_P2", 32'({a_E, a_Q, a_RW, a_oe}), 32'b1101);
    #2;
    a_rst = 1'b1;
    #1;
    chk("rst_async_ctl", 32'({a_E, a_Q, a_RW, a_oe, a_busy, a_ack}), 32'b001000);
    chk("rst_async_data", {16'h0, a_addr}, 32'h0);
    step(); step();
    a_rst = 1'b0;
    trace_a(15, 0, te, tq, tack, trw, toe, tbusy);
    chk("rst_no_ack", tack, 32'h0);
    chk("rst_idle_busy", tbusy, 32'h0);
    chk("rst_rdata", 32'(a_rdata), 32'h0);

    // Next request after reset completes normally
    a_req = 1'b1; a_wr = 1'b0; a_iaddr = 16'h0010;
    step();
    a_req = 1'b0;
    trace_a(12, 0, te, tq, tack, trw, toe, tbusy);
    chk("post_rst_ack", tack, 32'h0000_0200);
    chk("post_rst_E", te, 32'h0000_01E0);
    chk("post_rst_rdata", 32'(a_rdata), 32'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
